// File: rtl/irrigation_cycle_ctrl_pkg.sv
// Shared types and constants for the irrigation cycle controller.
package irrigation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int SEC_TENS_MAX = 5;
    localparam int UNITS_MAX    = 9;

    // Split a decimal minute count (1..99) into BCD tens/units.
    function automatic logic [3:0] bcd_tens(input int n);
        return 4'(n / 10);
    endfunction

    function automatic logic [3:0] bcd_units(input int n);
        return 4'(n % 10);
    endfunction

endpackage

// File: rtl/irrigation_cycle_ctrl_if.sv
// User/sensor inputs and valve/display outputs of the cycle controller.
interface irrigation_cycle_ctrl_if;
    logic       tick;
    logic       start;
    logic       stop;
    logic       mode;
    logic       rain;
    logic       water_low;
    logic       valve_open;
    logic       busy;
    logic       done;
    logic       alarm;
    logic [3:0] min_tens;
    logic [3:0] min_units;
    logic [2:0] sec_tens;
    logic [3:0] sec_units;

    modport slave (
        input  tick, start, stop, mode, rain, water_low,
        output valve_open, busy, done, alarm,
        output min_tens, min_units, sec_tens, sec_units
    );

    modport master (
        output tick, start, stop, mode, rain, water_low,
        input  valve_open, busy, done, alarm,
        input  min_tens, min_units, sec_tens, sec_units
    );
endinterface

// File: rtl/irrigation_cycle_ctrl_bcd_down_digit.sv
// One BCD down-counting digit; wraps 0 -> MAX and passes a borrow upward.
module bcd_down_digit #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    input  logic         borrow_in,
    output logic [W-1:0] q,
    output logic         borrow_out
);

    // Borrow ripples through only while this digit sits at zero.
    assign borrow_out = borrow_in & (q == '0);

    // Digit register: clear beats load beats decrement.
    always_ff @(posedge clk) begin
        if (clear)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (en && borrow_in)
            q <= (q == '0) ? W'(MAX) : q - 1'b1;
    end

endmodule

// File: rtl/irrigation_cycle_ctrl.sv
// One watering cycle: mm:ss BCD countdown, valve control, pause/abort.
module irrigation_cycle_ctrl
    import irrigation_pkg::*;
#(
    parameter int DRIP_MIN  = 10,
    parameter int SPRAY_MIN = 5
) (
    input  logic                    clk,
    input  logic                    clear,
    irrigation_cycle_ctrl_if.slave  bus
);

    if (DRIP_MIN < 1 || DRIP_MIN > 99) begin : g_bad_drip
        $error("DRIP_MIN must be in 1..99");
    end
    if (SPRAY_MIN < 1 || SPRAY_MIN > 99) begin : g_bad_spray
        $error("SPRAY_MIN must be in 1..99");
    end

    localparam logic [3:0] DRIP_T  = bcd_tens(DRIP_MIN);
    localparam logic [3:0] DRIP_U  = bcd_units(DRIP_MIN);
    localparam logic [3:0] SPRAY_T = bcd_tens(SPRAY_MIN);
    localparam logic [3:0] SPRAY_U = bcd_units(SPRAY_MIN);

    state_e     state_q, state_d;
    logic       load, dec, zero_digits, digit_clr;
    logic       sensors_ok, at_one, cnt_zero;
    logic       b_su, b_st, b_mu;
    logic [3:0] ld_mt, ld_mu;

    assign sensors_ok = !bus.rain && !bus.water_low;
    assign ld_mt      = bus.mode ? SPRAY_T : DRIP_T;
    assign ld_mu      = bus.mode ? SPRAY_U : DRIP_U;
    assign digit_clr  = clear | zero_digits;
    assign at_one     = (bus.min_tens == 4'd0) && (bus.min_units == 4'd0) &&
                        (bus.sec_tens == 3'd0) && (bus.sec_units == 4'd1);

    // Ripple-borrow chain, seconds units at the bottom; the top borrow
    // doubles as an all-zero detect.
    bcd_down_digit #(.MAX(UNITS_MAX), .W(4)) u_sec_units (
        .clk, .clear(digit_clr), .load, .load_val(4'd0), .en(dec),
        .borrow_in(1'b1), .q(bus.sec_units), .borrow_out(b_su));
    bcd_down_digit #(.MAX(SEC_TENS_MAX), .W(3)) u_sec_tens (
        .clk, .clear(digit_clr), .load, .load_val(3'd0), .en(dec),
        .borrow_in(b_su), .q(bus.sec_tens), .borrow_out(b_st));
    bcd_down_digit #(.MAX(UNITS_MAX), .W(4)) u_min_units (
        .clk, .clear(digit_clr), .load, .load_val(ld_mu), .en(dec),
        .borrow_in(b_st), .q(bus.min_units), .borrow_out(b_mu));
    bcd_down_digit #(.MAX(UNITS_MAX), .W(4)) u_min_tens (
        .clk, .clear(digit_clr), .load, .load_val(ld_mt), .en(dec),
        .borrow_in(b_mu), .q(bus.min_tens), .borrow_out(cnt_zero));

    // State register and sensor alarm.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            bus.alarm <= 1'b0;
        end else begin
            state_q   <= state_d;
            bus.alarm <= bus.water_low;
        end
    end

    // Next-state and digit-control decode.
    always_comb begin
        state_d     = state_q;
        load        = 1'b0;
        dec         = 1'b0;
        zero_digits = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start && sensors_ok) begin
                    state_d = ST_RUN;
                    load    = 1'b1;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    zero_digits = 1'b1;
                end else if (!sensors_ok) begin
                    state_d = ST_PAUSE;
                end else if (bus.tick && !cnt_zero) begin
                    dec = 1'b1;
                    if (at_one)
                        state_d = ST_DONE;
                end
            end
            ST_PAUSE: begin
                if (bus.stop) begin
                    state_d     = ST_IDLE;
                    zero_digits = 1'b1;
                end else if (sensors_ok) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.valve_open = (state_q == ST_RUN);
    assign bus.busy       = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign bus.done       = (state_q == ST_DONE);

endmodule
